regfile_mp: RTL
===============

// Module: regfile_mp
// PURPOSE
//   Parametrised multi-port register file for the pipelined core: NUM_RD registered read ports, NUM_WR write ports.
//   Sits between decode (read) and writeback (write); read data lands one cycle after address, in the execute stage.
//   Adds per-port read-enable stall hold, multi-writer priority, configurable width/depth and hardwired-zero entry.
// PARAMETERS
//   DATA_W    32  width of each register in bits
//   DEPTH     32  number of registers; power of two, >= 2
//   NUM_RD    2   number of read ports, 1..4
//   NUM_WR    1   number of write ports, 1..2
//   ZERO_R0   1   1: entry 0 reads as zero and ignores writes; 0: entry 0 is an ordinary register
//   Derived: ADDR_W = $clog2(DEPTH)
// PORTS
//   clk       in   1                  clock, all state updates on rising edge
//   rst       in   1                  asynchronous reset, active-high
//   wr_en     in   NUM_WR             per write port enable
//   wr_addr   in   NUM_WR x ADDR_W    write register index
//   wr_data   in   NUM_WR x DATA_W    write value
//   rd_en     in   NUM_RD             per read port enable; 0 = hold (stall)
//   rd_addr   in   NUM_RD x ADDR_W    read register index
//   rd_data   out  NUM_RD x DATA_W    registered read value
// BEHAVIOUR
//   - Reset: rst high clears every entry to 0 and every rd_data to 0 immediately, without waiting for clk.
//     Reset mid-operation discards in-flight writes that cycle; the first edge after rst falls behaves normally.
//   - Write: at the edge with wr_en[w]=1, mem[wr_addr[w]] <= wr_data[w].
//     If ZERO_R0=1 and wr_addr=0, the write is dropped.
//   - Write collision: two ports enabled to the same address -> the higher port index wins; the other is lost silently.
//   - Read: latency 1 cycle. At the edge with rd_en[r]=1, rd_data[r] <= value of mem[rd_addr[r]].
//     With rd_en[r]=0, rd_data[r] holds its previous value, even if the addressed entry is written.
//   - Zero entry: ZERO_R0=1 and rd_addr=0 -> rd_data <= 0 regardless of writes or bypass.
//   - Read ports are independent; the same address on several ports returns the same value.
//   - No handshake back-pressure: every enabled write and read completes in its cycle.
// CONFIGURATION
//   REGFILE_MP_BYPASS_EN defined:
//     Same-edge write-to-read forwarding. When rd_en[r]=1 and an enabled write targets rd_addr[r] in that cycle
//     (not the zero entry), rd_data[r] <= the winning write's wr_data, applying the collision priority above.
//   REGFILE_MP_BYPASS_EN undefined:
//     rd_data[r] <= the pre-write stored value; the new value is visible to reads from the next edge.
//     The pipeline hazard unit then adds one stall for back-to-back writeback/decode.
// STRUCTURE
//   Package regfile_mp_pkg:
//     - constants REGFILE_DATA_W, REGFILE_DEPTH and REGFILE_ADDR_W (defaults);
//     - typedefs reg_addr_t, reg_data_t;
//     - function wr_resolve(), returning the hit flag and winning data for an address over all write ports.
//   Sub-module regfile_mp_rdport, one instance per read port:
//     - holds the rd_data register, enable hold, zero-entry mask and the bypass mux (when compiled in).
//   Top level holds the storage array, the write decode and the generate loop over read ports.
// TESTING
//   1 Reset: write 0xDEADBEEF to x5, then assert rst asynchronously between edges
//     -> rd_data=0 at once; a read of x5 after release returns 0x00000000.
//   2 Basic: write x3=0x12345678; next cycle rd_en[0]=1, rd_addr[0]=3 -> rd_data[0]=0x12345678 one cycle later.
//     A write to x0 with value 0xFFFFFFFF, then a read of x0 -> 0 (ZERO_R0=1).
//   3 Same-cycle read/write of x7 (old 0x11, new 0x22):
//     with REGFILE_MP_BYPASS_EN -> rd_data=0x22; without -> 0x11, and the next read -> 0x22.
//   4 NUM_WR=2: both ports write x9 (port0 0xAAAA, port1 0x5555) in the same cycle -> a later read returns 0x5555.
//     With bypass, a same-cycle read also returns 0x5555.
//   5 Stall: rd_data[1]=0x42 from x4; hold rd_en[1]=0 for 3 cycles while writing x4=0x99
//     -> rd_data[1] stays 0x42; re-enable -> 0x99.
//   6 Params DEPTH=64, DATA_W=64, ZERO_R0=0: write x0=0xCAFE and x63=0x1 -> reads return 0xCAFE and 0x1 (no wrap).

Source files
------------

// File: rtl/regfile_mp_pkg.sv
// Shared types and the write-port resolution helper for regfile_mp.
// Also carries the upper bounds (address width, data width, write ports) that the resolver accepts.
package regfile_mp_pkg;

   localparam int REGFILE_DATA_W = 32;
   localparam int REGFILE_DEPTH  = 32;
   localparam int REGFILE_ADDR_W = $clog2(REGFILE_DEPTH);

   // Upper bounds the resolver is sized for; narrower instances zero-extend into these.
   localparam int MAX_ADDR_W = 8;
   localparam int MAX_DATA_W = 64;
   localparam int MAX_WR     = 2;

   typedef logic [REGFILE_ADDR_W-1:0] reg_addr_t;
   typedef logic [REGFILE_DATA_W-1:0] reg_data_t;

   typedef logic [MAX_ADDR_W-1:0] max_addr_t;
   typedef logic [MAX_DATA_W-1:0] max_data_t;

   typedef struct packed {
      logic      hit;
      max_data_t data;
   } wr_res_t;

   // Ascending scan, so the highest-indexed matching port overwrites lower ones.
   function automatic wr_res_t wr_resolve(
      input logic      [MAX_WR-1:0] en,
      input max_addr_t [MAX_WR-1:0] addr,
      input max_data_t [MAX_WR-1:0] data,
      input max_addr_t              target
   );
      wr_res_t r;
      r.hit  = 1'b0;
      r.data = '0;
      for (int w = 0; w < MAX_WR; w++) begin
         if (en[w] && addr[w] == target) begin
            r.hit  = 1'b1;
            r.data = data[w];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/regfile_mp_rdport.sv
// One registered read port: stall hold, zero-entry mask and, when REGFILE_MP_BYPASS_EN
// is defined, same-edge forwarding of the winning write.
module regfile_mp_rdport
   import regfile_mp_pkg::*;
#(
   parameter int DATA_W  = REGFILE_DATA_W,
   parameter int ADDR_W  = REGFILE_ADDR_W,
   parameter int ZERO_R0 = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] mem_data,
   input  logic              byp_hit,
   input  logic [DATA_W-1:0] byp_data,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] rd_next;

`ifdef REGFILE_MP_BYPASS_EN
   always_comb begin
      rd_next = byp_hit ? byp_data : mem_data;
      if (ZERO_R0 != 0 && rd_addr == '0) rd_next = '0;
   end
`else
   wire unused_byp = byp_hit ^ (^byp_data);

   always_comb begin
      rd_next = mem_data;
      if (ZERO_R0 != 0 && rd_addr == '0) rd_next = '0;
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst)        rd_data <= '0;
      else if (rd_en) rd_data <= rd_next;
   end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_WR write ports with higher-index priority, NUM_RD registered read ports.
// Optional same-edge write-to-read forwarding is compiled in with REGFILE_MP_BYPASS_EN.
module regfile_mp
   import regfile_mp_pkg::*;
#(
   parameter int DATA_W  = REGFILE_DATA_W,
   parameter int DEPTH   = REGFILE_DEPTH,
   parameter int NUM_RD  = 2,
   parameter int NUM_WR  = 1,
   parameter int ZERO_R0 = 1
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic [NUM_WR-1:0]                      wr_en,
   input  logic [NUM_WR-1:0][$clog2(DEPTH)-1:0]   wr_addr,
   input  logic [NUM_WR-1:0][DATA_W-1:0]          wr_data,
   input  logic [NUM_RD-1:0]                      rd_en,
   input  logic [NUM_RD-1:0][$clog2(DEPTH)-1:0]   rd_addr,
   output logic [NUM_RD-1:0][DATA_W-1:0]          rd_data
);

   localparam int ADDR_W = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];

   logic      [MAX_WR-1:0] wr_en_x;
   max_addr_t [MAX_WR-1:0] wr_addr_x;
   max_data_t [MAX_WR-1:0] wr_data_x;

   logic [DEPTH-1:0]             wr_hit;
   logic [DEPTH-1:0][DATA_W-1:0] wr_win;

   always_comb begin
      wr_en_x   = '0;
      wr_addr_x = '0;
      wr_data_x = '0;
      for (int w = 0; w < NUM_WR; w++) begin
         wr_en_x[w]   = wr_en[w];
         wr_addr_x[w] = max_addr_t'(wr_addr[w]);
         wr_data_x[w] = max_data_t'(wr_data[w]);
      end
   end

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr
      wr_res_t res;
      always_comb res = wr_resolve(wr_en_x, wr_addr_x, wr_data_x, max_addr_t'(gi));
      wire unused_res = ^res.data;
      assign wr_hit[gi] = res.hit && !(ZERO_R0 != 0 && gi == 0);
      assign wr_win[gi] = res.data[DATA_W-1:0];
   end

   // Reset clears the whole array, so storage is flops rather than a RAM macro.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (wr_hit[i]) mem[i] <= wr_win[i];
         end
      end
   end

   for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
      wr_res_t byp;
      always_comb byp = wr_resolve(wr_en_x, wr_addr_x, wr_data_x, max_addr_t'(rd_addr[gi]));
      wire unused_byp = ^byp.data;

      regfile_mp_rdport #(
         .DATA_W  (DATA_W),
         .ADDR_W  (ADDR_W),
         .ZERO_R0 (ZERO_R0)
      ) u_rdport (
         .clk      (clk),
         .rst      (rst),
         .rd_en    (rd_en[gi]),
         .rd_addr  (rd_addr[gi]),
         .mem_data (mem[rd_addr[gi]]),
         .byp_hit  (byp.hit),
         .byp_data (byp.data[DATA_W-1:0]),
         .rd_data  (rd_data[gi])
      );
   end

endmodule
